zone_stat_accum: RTL and testbench
==================================

Name: zone_stat_accum

Overview:
- Parametrised successor to the single-block luminance averager in the backlight-dimming path.
- Splits each active line into NZONE horizontal zones and accumulates per-zone sum and max over ZONE_H lines (one zone row).
- Emits one statistic per zone through a valid/ready stream to the backlight LUT/driver stage.
- Selectable max / average / mix mode, plus saturating gain.

Parameters:
- PIX_W, 8: pixel data width.
- NZONE, 8: zones per zone row; must be >= 2.
- ZONE_W_LOG2, 5: log2 of pixels per zone (default 32).
- ZONE_H_LOG2, 4: log2 of lines per zone row (default 16).

Ports:
- iODCK  in  1  pixel clock; all logic on its rising edge.
- iRST  in  1  asynchronous active-low reset.
- iPixelData  in  PIX_W  pixel luminance; valid while iH_Duty=1 and iV_Duty=1.
- iH_Duty  in  1  line-active qualifier.
- iV_Duty  in  1  frame-active qualifier.
- iMode  in  2  0=max, 1=average, 2=mix (max+avg)>>1, 3=average.
- iGain  in  2  left-shift applied to the selected value, saturating.
- iZoneReady  in  1  downstream ready.
- oZoneData  out  PIX_W  zone statistic.
- oZoneIdx  out  clog2(NZONE)  zone index of oZoneData.
- oZoneValid  out  1  oZoneData/oZoneIdx valid.
- oFrameDone  out  1  one-cycle pulse at the iV_Duty falling edge.
- oOverrun  out  1  one-cycle pulse when a new zone row arrives before the drain finishes.

Behaviour:
- Reset (iRST=0, async): all outputs 0; all counters, accumulators and max registers 0; FSM=IDLE; registered H/V duty copies 0.
- Edge detect: iH_Duty and iV_Duty are registered each cycle. The line-end event (LE) is the registered H=1 and current H=0, while iV_Duty=1.
- Pixel counter:
  - Clears on LE and whenever iV_Duty=0.
  - Increments each cycle with iH_Duty=1 and iV_Duty=1.
  - Zone index = counter >> ZONE_W_LOG2.
  - Pixels with index >= NZONE are ignored; the counter saturates and does not wrap.
- Accumulate: per zone, sum width SUM_W = PIX_W+ZONE_W_LOG2+ZONE_H_LOG2, which is exact with no overflow; max register of width PIX_W.
  - Each qualified pixel adds to sum[z].
  - max[z] <= max(max[z], pixel).
- Line counter (ZONE_H_LOG2 bits) increments on LE.
  - On the LE where line counter = 2^ZONE_H_LOG2-1 (row end), the counter wraps to 0.
  - At row end, every zone's selected value is computed and latched into a result buffer, and sum/max are cleared.
  - Pixels of the next line accumulate into the cleared registers with no lost cycle.
- Value computation at latch, using iMode and iGain sampled at the row-end cycle:
  - avg = sum >> (ZONE_W_LOG2+ZONE_H_LOG2).
  - mix = (max+avg)>>1, computed in PIX_W+1 bits.
  - Result = min(sel << iGain, 2^PIX_W-1).
- Drain FSM:
  - IDLE: on row end go to DRAIN, idx=0, oZoneValid=1.
  - DRAIN: on iZoneValid&iZoneReady, idx++. The beat with idx=NZONE-1 accepted goes to IDLE with oZoneValid=0 the next cycle.
  - While iZoneReady=0, oZoneData and oZoneIdx hold stable.
  - Latency: oZoneValid rises the cycle after the row-end LE edge.
- Row end while in DRAIN: the buffer is overwritten, idx restarts at 0, oOverrun pulses one cycle, and the FSM stays in DRAIN.
- iV_Duty falling edge:
  - oFrameDone pulses one cycle.
  - Partial zone row (line counter != 0) is discarded: accumulators, max and line counter are cleared.
  - An in-progress drain continues unaffected.
- iV_Duty=0: no accumulation; counters are held cleared.
- Row end and an accepted beat in the same cycle: row end wins (buffer overwrite, idx=0).
- Reset mid-drain: immediate return to IDLE and all-zero state.

Decomposition:
- Package zone_stat_pkg holds:
  - mode encodings MODE_MAX/MODE_AVG/MODE_MIX;
  - SUM_W and IDX_W derivation functions;
  - the saturating-shift function.
- One natural sub-module, zone_stat_cell: a single zone's sum/max accumulator with clear and mode/gain value output, instantiated NZONE times via generate.
- The top holds the counters, edge detect, result buffer and drain FSM.

Test Plan:
- Bench params PIX_W=8, NZONE=4, ZONE_W_LOG2=2, ZONE_H_LOG2=1.
- Constant 100 on all pixels, 2 lines, iMode=1, iGain=0, ready=1 -> beats idx 0..3, data 100 each, on consecutive cycles starting the cycle after the 2nd LE.
- Zone 2 pixels = 200 on one pixel and 0 elsewhere, iMode=0 -> zone 2 data 200, other zones 0. With iMode=2 -> zone 2 data (200+25)>>1 = 112.
- Constant 100, iMode=1, iGain=2 -> 400 saturates -> all zones 255. iGain=1 -> 200.
- ready held 0 for 5 cycles after valid -> idx 0, data stable, valid=1 throughout. Release -> four beats, then valid=0.
- ready=0 through a second row end -> oOverrun one-cycle pulse, idx restarts at 0, data equals the new row's values.
- iV_Duty falls after 1 of 2 lines -> oFrameDone pulse, no output beats. Next frame 2 lines of 50 -> data 50, not a blend with the discarded line.
- iRST low during a DRAIN beat -> oZoneValid, oZoneData, oZoneIdx = 0 immediately (async). After release, no beats until a full row.

Source files
------------

// File: rtl/zone_stat_pkg.sv
// Shared types and helpers for the zone statistics accumulator.
package zone_stat_pkg;

  // Statistic selection; code 3 also selects the average.
  typedef enum logic [1:0] {
    MODE_MAX     = 2'd0,
    MODE_AVG     = 2'd1,
    MODE_MIX     = 2'd2,
    MODE_AVG_ALT = 2'd3
  } mode_e;

  // Result drain state.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

  // Width of the value path fed to the saturating shift.
  localparam int unsigned SAT_W = 32;

  // Per-zone sum width: exact for 2^ZW * 2^ZH pixels of PIX_W bits.
  function automatic int unsigned sum_w(input int unsigned pix_w,
                                        input int unsigned zw_log2,
                                        input int unsigned zh_log2);
    return pix_w + zw_log2 + zh_log2;
  endfunction

  // Zone index width.
  function automatic int unsigned idx_w(input int unsigned nzone);
    return (nzone > 1) ? $clog2(nzone) : 1;
  endfunction

  // Left shift by gain, clamped to 2^pix_w-1.
  function automatic logic [SAT_W-1:0] sat_shl(input logic [SAT_W-1:0] v,
                                               input logic [1:0]       gain,
                                               input int unsigned      pix_w);
    logic [SAT_W+2:0] s;
    logic [SAT_W+2:0] one;
    logic [SAT_W+2:0] lim;
    s   = {3'b000, v} << gain;
    one = {{(SAT_W+2){1'b0}}, 1'b1};
    lim = (one << pix_w) - one;
    return (s > lim) ? lim[SAT_W-1:0] : s[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/zone_stat_cell.sv
// One zone's sum/max accumulator with mode/gain statistic output.
module zone_stat_cell
  import zone_stat_pkg::*;
#(
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned ZONE_W_LOG2 = 5,
  parameter int unsigned ZONE_H_LOG2 = 4
) (
  input  logic             iODCK,
  input  logic             iRST,
  input  logic             i_clr,
  input  logic             i_acc,
  input  logic [PIX_W-1:0] i_pix,
  input  logic [1:0]       i_mode,
  input  logic [1:0]       i_gain,
  output logic [PIX_W-1:0] o_value
);

  localparam int unsigned SUM_W  = sum_w(PIX_W, ZONE_W_LOG2, ZONE_H_LOG2);
  localparam int unsigned AVG_SH = ZONE_W_LOG2 + ZONE_H_LOG2;

  logic [SUM_W-1:0] r_sum;
  logic [PIX_W-1:0] r_max;
  logic [SUM_W-1:0] w_pix_ext;
  logic [PIX_W-1:0] w_avg;
  logic [PIX_W:0]   w_mix_sum;
  logic [PIX_W:0]   w_mix;
  logic [PIX_W:0]   w_sel;
  logic [SAT_W-1:0] w_sel_ext;
  logic [SAT_W-1:0] w_sat;

  // Accumulate qualified pixels; a clear restarts from the current pixel if any.
  always_ff @(posedge iODCK or negedge iRST) begin
    if (!iRST) begin
      r_sum <= '0;
      r_max <= '0;
    end else if (i_clr) begin
      r_sum <= i_acc ? w_pix_ext : '0;
      r_max <= i_acc ? i_pix : '0;
    end else if (i_acc) begin
      r_sum <= r_sum + w_pix_ext;
      if (i_pix > r_max) r_max <= i_pix;
    end
  end

  // Average, mix, mode select and saturating gain.
  always_comb begin
    w_pix_ext              = '0;
    w_pix_ext[PIX_W-1:0]   = i_pix;
    w_avg                  = r_sum[AVG_SH +: PIX_W];
    w_mix_sum              = {1'b0, r_max} + {1'b0, w_avg};
    w_mix                  = w_mix_sum >> 1;
    case (i_mode)
      MODE_MAX: w_sel = {1'b0, r_max};
      MODE_MIX: w_sel = w_mix;
      default:  w_sel = {1'b0, w_avg};
    endcase
    w_sel_ext              = '0;
    w_sel_ext[PIX_W:0]     = w_sel;
    w_sat                  = sat_shl(w_sel_ext, i_gain, PIX_W);
    // Any bit above PIX_W would also mean saturation.
    o_value = w_sat[PIX_W-1:0] | {PIX_W{|w_sat[SAT_W-1:PIX_W]}};
  end

endmodule

// File: rtl/zone_stat_accum.sv
// Per-zone luminance statistics over one zone row, drained as a valid/ready stream.
module zone_stat_accum
  import zone_stat_pkg::*;
#(
  parameter int unsigned PIX_W       = 8,
  parameter int unsigned NZONE       = 8,
  parameter int unsigned ZONE_W_LOG2 = 5,
  parameter int unsigned ZONE_H_LOG2 = 4
) (
  input  logic                    iODCK,
  input  logic                    iRST,
  input  logic [PIX_W-1:0]        iPixelData,
  input  logic                    iH_Duty,
  input  logic                    iV_Duty,
  input  logic [1:0]              iMode,
  input  logic [1:0]              iGain,
  input  logic                    iZoneReady,
  output logic [PIX_W-1:0]        oZoneData,
  output logic [idx_w(NZONE)-1:0] oZoneIdx,
  output logic                    oZoneValid,
  output logic                    oFrameDone,
  output logic                    oOverrun
);

  localparam int unsigned IDX_W  = idx_w(NZONE);
  localparam int unsigned PCNT_W = IDX_W + ZONE_W_LOG2 + 1;
  localparam int unsigned ZIDX_W = PCNT_W - ZONE_W_LOG2;
  localparam logic [PCNT_W-1:0] PCNT_LIM = PCNT_W'(NZONE) << ZONE_W_LOG2;
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NZONE - 1);

  logic                   r_h;
  logic                   r_v;
  logic [PCNT_W-1:0]      r_pcnt;
  logic [ZONE_H_LOG2-1:0] r_line;
  logic [PIX_W-1:0]       r_buf [NZONE];
  drain_state_e           r_state;
  drain_state_e           w_state_nxt;
  logic [IDX_W-1:0]       r_idx;
  logic [IDX_W-1:0]       w_idx_nxt;
  logic                   r_overrun;
  logic                   w_overrun;
  logic                   r_fdone;

  logic                   w_le;
  logic                   w_vfall;
  logic                   w_row_end;
  logic                   w_pix_ok;
  logic                   w_clr;
  logic [ZIDX_W-1:0]      w_zone;
  logic [NZONE-1:0]       w_acc;
  logic [PIX_W-1:0]       w_val [NZONE];

  assign w_le      = r_h && !iH_Duty && iV_Duty;
  assign w_vfall   = r_v && !iV_Duty;
  assign w_row_end = w_le && (r_line == '1);
  assign w_pix_ok  = iH_Duty && iV_Duty && (r_pcnt < PCNT_LIM);
  assign w_zone    = r_pcnt[PCNT_W-1:ZONE_W_LOG2];
  // Holding the cells cleared while the frame is inactive discards any partial row.
  assign w_clr     = w_row_end || !iV_Duty;

  // Registered duty copies for edge detection.
  always_ff @(posedge iODCK or negedge iRST) begin
    if (!iRST) begin
      r_h <= 1'b0;
      r_v <= 1'b0;
    end else begin
      r_h <= iH_Duty;
      r_v <= iV_Duty;
    end
  end

  // Pixel position within the line; stops at the end of the last zone.
  always_ff @(posedge iODCK or negedge iRST) begin
    if (!iRST)                  r_pcnt <= '0;
    else if (!iV_Duty || w_le)  r_pcnt <= '0;
    else if (w_pix_ok)          r_pcnt <= r_pcnt + PCNT_W'(1);
  end

  // Line position within the zone row; wraps at row end.
  always_ff @(posedge iODCK or negedge iRST) begin
    if (!iRST)         r_line <= '0;
    else if (!iV_Duty) r_line <= '0;
    else if (w_le)     r_line <= r_line + ZONE_H_LOG2'(1);
  end

  for (genvar g = 0; g < NZONE; g++) begin : g_zone
    assign w_acc[g] = w_pix_ok && (w_zone == ZIDX_W'(g));
    zone_stat_cell #(
      .PIX_W       (PIX_W),
      .ZONE_W_LOG2 (ZONE_W_LOG2),
      .ZONE_H_LOG2 (ZONE_H_LOG2)
    ) u_cell (
      .iODCK   (iODCK),
      .iRST    (iRST),
      .i_clr   (w_clr),
      .i_acc   (w_acc[g]),
      .i_pix   (iPixelData),
      .i_mode  (iMode),
      .i_gain  (iGain),
      .o_value (w_val[g])
    );
  end

  // Result buffer: snapshot of every zone's statistic at row end.
  always_ff @(posedge iODCK or negedge iRST) begin
    if (!iRST) begin
      for (int unsigned i = 0; i < NZONE; i++) r_buf[i] <= '0;
    end else if (w_row_end) begin
      for (int unsigned i = 0; i < NZONE; i++) r_buf[i] <= w_val[i];
    end
  end

  // Drain state, index and status pulse registers.
  always_ff @(posedge iODCK or negedge iRST) begin
    if (!iRST) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_overrun <= 1'b0;
      r_fdone   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_overrun <= w_overrun;
      r_fdone   <= w_vfall;
    end
  end

  // Drain next-state: row end restarts the drain and takes priority over a beat.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_overrun   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_row_end) begin
          w_state_nxt = ST_DRAIN;
          w_idx_nxt   = '0;
        end
      end
      ST_DRAIN: begin
        if (w_row_end) begin
          w_idx_nxt = '0;
          w_overrun = 1'b1;
        end else if (iZoneReady) begin
          if (r_idx == IDX_LAST) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = '0;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  assign oZoneValid = (r_state == ST_DRAIN);
  assign oZoneIdx   = r_idx;
  assign oZoneData  = oZoneValid ? r_buf[r_idx] : '0;
  assign oOverrun   = r_overrun;
  assign oFrameDone = r_fdone;

endmodule

// File: tb/tb_zone_stat_accum.sv
// Randomised self-checking bench for zone_stat_accum with a behavioural zone model.
`timescale 1ns/1ps
module tb_zone_stat_accum;

  localparam int NZ       = 4;
  localparam int ZPIX     = 4;
  localparam int NLINE    = 2;
  localparam int LINE_ACT = 18;  // two pixels past the last zone

  logic       iODCK = 1'b0;
  logic       iRST = 1'b0;
  logic [7:0] iPixelData = '0;
  logic       iH_Duty = 1'b0;
  logic       iV_Duty = 1'b0;
  logic [1:0] iMode = '0;
  logic [1:0] iGain = '0;
  logic       iZoneReady = 1'b0;
  logic [7:0] oZoneData;
  logic [1:0] oZoneIdx;
  logic       oZoneValid;
  logic       oFrameDone;
  logic       oOverrun;

  zone_stat_accum #(
    .PIX_W       (8),
    .NZONE       (4),
    .ZONE_W_LOG2 (2),
    .ZONE_H_LOG2 (1)
  ) dut (
    .iODCK      (iODCK),
    .iRST       (iRST),
    .iPixelData (iPixelData),
    .iH_Duty    (iH_Duty),
    .iV_Duty    (iV_Duty),
    .iMode      (iMode),
    .iGain      (iGain),
    .iZoneReady (iZoneReady),
    .oZoneData  (oZoneData),
    .oZoneIdx   (oZoneIdx),
    .oZoneValid (oZoneValid),
    .oFrameDone (oFrameDone),
    .oOverrun   (oOverrun)
  );

  always #5 iODCK = ~iODCK;

  typedef struct {
    int data;
    int idx;
    int cyc;
  } beat_t;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    ovr_cnt = 0;
  int    fd_cnt = 0;
  int    last_le = 0;
  beat_t beats[$];
  int    px[4][LINE_ACT];

  always @(posedge iODCK) cyc <= cyc + 1;

  // Record accepted beats and status pulses between clock edges.
  always @(negedge iODCK) begin
    if (oZoneValid && iZoneReady) beats.push_back(beat_t'{int'(oZoneData), int'(oZoneIdx), cyc});
    if (oOverrun) ovr_cnt++;
    if (oFrameDone) fd_cnt++;
  end

  // Reference: zone statistic of zone row `row` from the pixel table.
  function automatic int model(input int row, input int z, input int mode, input int gain);
    int s, m, v, avg, sel, r;
    s = 0;
    m = 0;
    for (int l = 0; l < NLINE; l++)
      for (int k = 0; k < ZPIX; k++) begin
        v = px[row*NLINE + l][z*ZPIX + k];
        s += v;
        if (v > m) m = v;
      end
    avg = s / (ZPIX * NLINE);
    case (mode)
      0:       sel = m;
      2:       sel = (m + avg) / 2;
      default: sel = avg;
    endcase
    r = sel * (1 << gain);
    return (r > 255) ? 255 : r;
  endfunction

  task automatic tick();
    @(posedge iODCK);
    #2;
  endtask

  task automatic fill_const(input int row, input int v);
    for (int l = 0; l < NLINE; l++)
      for (int p = 0; p < LINE_ACT; p++)
        px[row*NLINE + l][p] = (p >= NZ*ZPIX) ? 255 : v;
  endtask

  task automatic fill_rand(input int row);
    for (int l = 0; l < NLINE; l++)
      for (int p = 0; p < LINE_ACT; p++)
        px[row*NLINE + l][p] = (p >= NZ*ZPIX) ? 255 : int'($urandom_range(0, 255));
  endtask

  task automatic drive_line(input int l, input int blank);
    for (int p = 0; p < LINE_ACT; p++) begin
      iH_Duty    = 1'b1;
      iPixelData = 8'(px[l][p]);
      tick();
    end
    iH_Duty    = 1'b0;
    iPixelData = '0;
    last_le    = cyc + 1;
    tick();
    repeat (blank) tick();
  endtask

  task automatic drive_frame(input int nlines);
    iV_Duty = 1'b1;
    repeat (2) tick();
    for (int l = 0; l < nlines; l++) drive_line(l, 8);
    iV_Duty = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    iRST = 1'b0;
    repeat (3) tick();
    checks++; if (oZoneValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", oZoneValid); end
    checks++; if (oZoneData !== 8'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", oZoneData); end
    checks++; if (oZoneIdx !== 2'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", oZoneIdx); end
    checks++; if (oFrameDone !== 1'b0) begin errors++; $display("FAIL reset_framedone: got %0b expected 0", oFrameDone); end
    checks++; if (oOverrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b expected 0", oOverrun); end
    iRST = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_values();
    int kind [10] = '{0, 1, 1, 0, 0, 2, 2, 2, 2, 2};
    int md   [10] = '{1, 0, 2, 1, 1, 3, 2, 0, 1, 2};
    int gn   [10] = '{0, 0, 0, 2, 1, 0, 1, 3, 0, 0};
    int exp_d;
    for (int s = 0; s < 14; s++) begin
      if (s < 10) begin
        if (kind[s] == 0) fill_const(0, 100);
        else if (kind[s] == 1) begin fill_const(0, 0); px[0][2*ZPIX + 1] = 200; end
        else fill_rand(0);
        iMode = 2'(md[s]);
        iGain = 2'(gn[s]);
      end else begin
        fill_rand(0);
        iMode = 2'($urandom_range(0, 3));
        iGain = 2'($urandom_range(0, 3));
      end
      iZoneReady = 1'b1;
      beats.delete();
      drive_frame(2);
      checks++;
      if (beats.size() != NZ) begin errors++; $display("FAIL values_count s%0d: got %0d beats expected %0d", s, beats.size(), NZ); end
      for (int i = 0; i < NZ; i++) begin
        if (i < beats.size()) begin
          exp_d = model(0, i, int'(iMode), int'(iGain));
          checks++; if (beats[i].idx != i) begin errors++; $display("FAIL values_idx s%0d b%0d: got %0d expected %0d", s, i, beats[i].idx, i); end
          checks++; if (beats[i].data != exp_d) begin errors++; $display("FAIL values_data s%0d z%0d: got %0d expected %0d", s, i, beats[i].data, exp_d); end
          checks++; if (beats[i].cyc != last_le + i) begin errors++; $display("FAIL values_timing s%0d b%0d: got cycle %0d expected %0d", s, i, beats[i].cyc, last_le + i); end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int exp_d;
    fill_rand(0);
    iMode = 2'd1;
    iGain = 2'd0;
    iZoneReady = 1'b0;
    iV_Duty = 1'b1;
    repeat (2) tick();
    drive_line(0, 8);
    drive_line(1, 0);
    exp_d = model(0, 0, 1, 0);
    for (int c = 0; c < 5; c++) begin
      checks++; if (oZoneValid !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d: got %0b expected 1", c, oZoneValid); end
      checks++; if (oZoneIdx !== 2'd0) begin errors++; $display("FAIL bp_idx c%0d: got %0d expected 0", c, oZoneIdx); end
      checks++; if (int'(oZoneData) != exp_d) begin errors++; $display("FAIL bp_data c%0d: got %0d expected %0d", c, oZoneData, exp_d); end
      tick();
    end
    beats.delete();
    iZoneReady = 1'b1;
    repeat (6) tick();
    checks++; if (beats.size() != NZ) begin errors++; $display("FAIL bp_count: got %0d beats expected %0d", beats.size(), NZ); end
    for (int i = 0; i < NZ; i++) begin
      if (i < beats.size()) begin
        exp_d = model(0, i, 1, 0);
        checks++; if (beats[i].idx != i || beats[i].data != exp_d) begin errors++; $display("FAIL bp_beat b%0d: got idx %0d data %0d expected idx %0d data %0d", i, beats[i].idx, beats[i].data, i, exp_d); end
      end
    end
    checks++; if (oZoneValid !== 1'b0) begin errors++; $display("FAIL bp_valid_end: got %0b expected 0", oZoneValid); end
    iV_Duty = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_overrun();
    int exp_d;
    fill_const(0, 60);
    fill_rand(1);
    iMode = 2'd2;
    iGain = 2'd0;
    iZoneReady = 1'b0;
    ovr_cnt = 0;
    iV_Duty = 1'b1;
    repeat (2) tick();
    drive_line(0, 8);
    drive_line(1, 8);
    checks++; if (ovr_cnt != 0) begin errors++; $display("FAIL ovr_early: got %0d pulses expected 0", ovr_cnt); end
    drive_line(2, 8);
    drive_line(3, 2);
    exp_d = model(1, 0, 2, 0);
    checks++; if (ovr_cnt != 1) begin errors++; $display("FAIL ovr_pulse: got %0d pulse cycles expected 1", ovr_cnt); end
    checks++; if (oZoneValid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %0b expected 1", oZoneValid); end
    checks++; if (oZoneIdx !== 2'd0) begin errors++; $display("FAIL ovr_idx: got %0d expected 0", oZoneIdx); end
    checks++; if (int'(oZoneData) != exp_d) begin errors++; $display("FAIL ovr_data: got %0d expected %0d", oZoneData, exp_d); end
    beats.delete();
    iZoneReady = 1'b1;
    repeat (6) tick();
    checks++; if (beats.size() != NZ) begin errors++; $display("FAIL ovr_count: got %0d beats expected %0d", beats.size(), NZ); end
    for (int i = 0; i < NZ; i++) begin
      if (i < beats.size()) begin
        exp_d = model(1, i, 2, 0);
        checks++; if (beats[i].idx != i || beats[i].data != exp_d) begin errors++; $display("FAIL ovr_beat b%0d: got idx %0d data %0d expected idx %0d data %0d", i, beats[i].idx, beats[i].data, i, exp_d); end
      end
    end
    iV_Duty = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_frame_discard();
    int exp_d;
    fill_const(0, 200);
    iMode = 2'd1;
    iGain = 2'd0;
    iZoneReady = 1'b1;
    beats.delete();
    fd_cnt = 0;
    iV_Duty = 1'b1;
    repeat (2) tick();
    drive_line(0, 8);
    iV_Duty = 1'b0;
    repeat (4) tick();
    checks++; if (fd_cnt != 1) begin errors++; $display("FAIL fd_pulse: got %0d pulse cycles expected 1", fd_cnt); end
    checks++; if (beats.size() != 0) begin errors++; $display("FAIL fd_nobeats: got %0d beats expected 0", beats.size()); end
    fill_const(0, 50);
    beats.delete();
    drive_frame(2);
    checks++; if (beats.size() != NZ) begin errors++; $display("FAIL fd_count: got %0d beats expected %0d", beats.size(), NZ); end
    for (int i = 0; i < NZ; i++) begin
      if (i < beats.size()) begin
        exp_d = model(0, i, 1, 0);
        checks++; if (beats[i].data != exp_d) begin errors++; $display("FAIL fd_data z%0d: got %0d expected %0d", i, beats[i].data, exp_d); end
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    int exp_d;
    fill_const(0, 90);
    iMode = 2'd1;
    iGain = 2'd0;
    iZoneReady = 1'b0;
    iV_Duty = 1'b1;
    repeat (2) tick();
    drive_line(0, 2);
    drive_line(1, 2);
    checks++; if (oZoneValid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %0b expected 1", oZoneValid); end
    #1 iRST = 1'b0;
    #1;
    checks++; if (oZoneValid !== 1'b0) begin errors++; $display("FAIL rst_async_valid: got %0b expected 0", oZoneValid); end
    checks++; if (oZoneData !== 8'd0) begin errors++; $display("FAIL rst_async_data: got %0d expected 0", oZoneData); end
    checks++; if (oZoneIdx !== 2'd0) begin errors++; $display("FAIL rst_async_idx: got %0d expected 0", oZoneIdx); end
    tick();
    iRST = 1'b1;
    iZoneReady = 1'b1;
    iV_Duty = 1'b0;
    beats.delete();
    repeat (3) tick();
    iV_Duty = 1'b1;
    repeat (2) tick();
    drive_line(0, 8);
    iV_Duty = 1'b0;
    repeat (4) tick();
    checks++; if (beats.size() != 0) begin errors++; $display("FAIL rst_nobeats: got %0d beats expected 0", beats.size()); end
    drive_frame(2);
    checks++; if (beats.size() != NZ) begin errors++; $display("FAIL rst_count: got %0d beats expected %0d", beats.size(), NZ); end
    for (int i = 0; i < NZ; i++) begin
      if (i < beats.size()) begin
        exp_d = model(0, i, 1, 0);
        checks++; if (beats[i].data != exp_d) begin errors++; $display("FAIL rst_data z%0d: got %0d expected %0d", i, beats[i].data, exp_d); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_values();
    test_backpressure();
    test_overrun();
    test_frame_discard();
    test_reset_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
